// File: rtl/qam_pkg.sv
// Shared types, widths and helper functions for the 16QAM slicer/demapper.
package qam_pkg;

  localparam int unsigned SYM_W    = 18;
  localparam int unsigned SYM_BITS = 4;
  localparam int unsigned CNT_W    = 3;

  typedef logic [SYM_BITS-1:0]    sym_t;
  typedef logic signed [SYM_W-1:0] samp_t;
  typedef logic [SYM_W-1:0]        mag_t;

  // Per-axis Gray code: +3 -> 00, +1 -> 01, -1 -> 11, -3 -> 10
  function automatic logic [1:0] gray_map(input logic sign, input logic inner);
    return {sign, inner};
  endfunction

  // Magnitude with the most negative code clamped to the largest positive value
  function automatic mag_t abs_sat(input samp_t x);
    mag_t u;
    u = mag_t'(x);
    if (u == {1'b1, {(SYM_W-1){1'b0}}}) begin
      return {1'b0, {(SYM_W-1){1'b1}}};
    end else if (u[SYM_W-1]) begin
      return ~u + mag_t'(1);
    end else begin
      return u;
    end
  endfunction

endpackage

// File: rtl/qam16_slicer_demap_if.sv
// Baseband symbol stream: I/Q samples qualified by a one-cycle strobe.
interface qam16_slicer_demap_if;
  import qam_pkg::*;

  samp_t di;
  samp_t dq;
  logic  sync;

  modport master (output di, dq, sync);
  modport slave  (input  di, dq, sync);
endinterface

// File: rtl/qam_bit_serializer.sv
// Shifts each demapped symbol out MSB first, one bit per clock, flagging overruns.
module qam_bit_serializer
  import qam_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  sym_t i_sym,
  input  logic i_sym_valid,
  output logic o_bit_out,
  output logic o_bit_valid,
  output logic o_overrun
);

  logic [SYM_BITS-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;     // bits left including the one on o_bit_out
  logic                r_bit_out;
  logic                r_bit_valid;
  logic                r_overrun;

  // Load on a new symbol (no gap after the last bit), otherwise shift until empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_sym_valid) begin
        r_bit_out   <= i_sym[SYM_BITS-1];
        r_shift     <= {i_sym[SYM_BITS-2:0], 1'b0};
        r_cnt       <= CNT_W'(SYM_BITS);
        r_bit_valid <= 1'b1;
        if (r_cnt > CNT_W'(1)) begin
          r_overrun <= 1'b1;
        end
      end else if (r_cnt > CNT_W'(1)) begin
        r_bit_out <= r_shift[SYM_BITS-1];
        r_shift   <= {r_shift[SYM_BITS-2:0], 1'b0};
        r_cnt     <= r_cnt - CNT_W'(1);
      end else if (r_cnt == CNT_W'(1)) begin
        r_bit_out   <= 1'b0;
        r_bit_valid <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign o_bit_out   = r_bit_out;
  assign o_bit_valid = r_bit_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/qam16_slicer_demap.sv
// 16QAM hard-decision slicer with adaptive threshold, Gray demap and bit serializer.
module qam16_slicer_demap
  import qam_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 8,
  parameter logic [17:0] THR_INIT = 18'd16384
) (
  input  logic                   clk,
  input  logic                   rst,
  qam16_slicer_demap_if.slave    in_if,
  output sym_t                   sym,
  output logic                   sym_valid,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic [SYM_W-1:0]       thresh,
  output logic                   overrun
);

  localparam int unsigned ACC_W = 19 + AVG_LOG2;

  mag_t                r_ai;
  mag_t                r_aq;
  logic                r_si;
  logic                r_sq;
  logic                r_cap_vld;

  sym_t                r_sym;
  logic                r_sym_valid;
  mag_t                r_thresh;
  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;

  logic [ACC_W-1:0]    w_sum;
  mag_t                w_thr_new;

  // Capture magnitudes and signs of the strobed sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ai      <= '0;
      r_aq      <= '0;
      r_si      <= 1'b0;
      r_sq      <= 1'b0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= in_if.sync;
      if (in_if.sync) begin
        r_ai <= abs_sat(in_if.di);
        r_aq <= abs_sat(in_if.dq);
        r_si <= in_if.di[SYM_W-1];
        r_sq <= in_if.dq[SYM_W-1];
      end
    end
  end

  // Block sum including the symbol being sliced; mean |x| per axis is sum/2^(AVG_LOG2+1)
  assign w_sum     = r_acc + ACC_W'(r_ai) + ACC_W'(r_aq);
  assign w_thr_new = SYM_W'(w_sum >> (AVG_LOG2 + 1));

  // Slice against the current threshold and update the averaging block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_thresh    <= THR_INIT;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_sym_valid <= r_cap_vld;
      if (r_cap_vld) begin
        r_sym <= {gray_map(r_si, r_ai < r_thresh), gray_map(r_sq, r_aq < r_thresh)};
        if (r_cnt == '1) begin
          r_thresh <= w_thr_new;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + AVG_LOG2'(1);
        end
      end
    end
  end

  qam_bit_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_sym       (r_sym),
    .i_sym_valid (r_sym_valid),
    .o_bit_out   (bit_out),
    .o_bit_valid (bit_valid),
    .o_overrun   (overrun)
  );

  assign sym       = r_sym;
  assign sym_valid = r_sym_valid;
  assign thresh    = r_thresh;

endmodule

// File: tb/tb_qam16_slicer_demap.sv
// Directed bench for qam16_slicer_demap: vector table plus multi-cycle sequences.
module tb_qam16_slicer_demap;
  import qam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sym_t        sym;
  logic        sym_valid;
  logic        bit_out;
  logic        bit_valid;
  logic [17:0] thresh;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  qam16_slicer_demap_if bus ();

  qam16_slicer_demap #(.AVG_LOG2(4), .THR_INIT(18'd16384)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus),
    .sym       (sym),
    .sym_valid (sym_valid),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .thresh    (thresh),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [17:0] di;
    logic signed [17:0] dq;
    logic [3:0]         exp_sym;
  } vec_t;

  vec_t               vecs[8];
  logic signed [17:0] lvl[4];
  logic [1:0]         code[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated symbol: checks latency, decision and the 4 serial bits
  task automatic send_and_check(input logic signed [17:0] di, input logic signed [17:0] dq,
                                input logic [3:0] exp_sym, input string name);
    bus.di = di;
    bus.dq = dq;
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    chk({name, " sym_valid early"}, 32'(sym_valid), 32'd0);
    tick();
    chk({name, " sym_valid"}, 32'(sym_valid), 32'd1);
    chk({name, " sym"}, 32'(sym), 32'(exp_sym));
    for (int b = 3; b >= 0; b--) begin
      tick();
      chk($sformatf("%s bit%0d", name, b), {30'd0, bit_valid, bit_out}, {30'd0, 1'b1, exp_sym[b]});
    end
    tick();
    chk({name, " idle"}, {30'd0, bit_valid, bit_out}, 32'd0);
  endtask

  initial begin
    logic [3:0] e;
    int         idx;

    vecs[0] = '{18'sd30000,   -18'sd10000,  4'b0011};
    vecs[1] = '{18'sd16384,   -18'sd131072, 4'b0010};
    vecs[2] = '{-18'sd30000,  18'sd10000,   4'b1001};
    vecs[3] = '{-18'sd10000,  -18'sd30000,  4'b1110};
    vecs[4] = '{18'sd10000,   18'sd30000,   4'b0100};
    vecs[5] = '{18'sd16383,   -18'sd16383,  4'b0111};
    vecs[6] = '{-18'sd16384,  18'sd0,       4'b1001};
    vecs[7] = '{18'sd131071,  -18'sd1,      4'b0011};
    lvl[0] = 18'sd30000;  code[0] = 2'b00;
    lvl[1] = 18'sd10000;  code[1] = 2'b01;
    lvl[2] = -18'sd10000; code[2] = 2'b11;
    lvl[3] = -18'sd30000; code[3] = 2'b10;

    bus.di = '0;
    bus.dq = '0;
    bus.sync = 1'b0;

    // Reset state
    do_reset();
    chk("rst sym", 32'(sym), 32'd0);
    chk("rst sym_valid", 32'(sym_valid), 32'd0);
    chk("rst bits", {30'd0, bit_valid, bit_out}, 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst thresh", 32'(thresh), 32'd16384);

    // Vector table at the initial threshold
    for (int i = 0; i < 8; i++) begin
      send_and_check(vecs[i].di, vecs[i].dq, vecs[i].exp_sym, $sformatf("vec%0d", i));
      tick();
    end
    chk("table thresh", 32'(thresh), 32'd16384);
    chk("table overrun", 32'(overrun), 32'd0);

    // Adaptation: 16 symbols of magnitude 20000 on both axes
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.di = ((k & 1) != 0) ? -18'sd20000 : 18'sd20000;
      bus.dq = ((k & 2) != 0) ? -18'sd20000 : 18'sd20000;
      bus.sync = 1'b1;
      tick();
      bus.sync = 1'b0;
      if (k == 15) chk("adapt thresh before", 32'(thresh), 32'd16384);
      tick();
      chk($sformatf("adapt sym%0d", k), 32'(sym),
          {28'd0, ((k & 1) != 0), 1'b0, ((k & 2) != 0), 1'b0});
      if (k == 15) chk("adapt thresh after", 32'(thresh), 32'd20000);
      tick();
      tick();
    end
    chk("adapt overrun", 32'(overrun), 32'd0);
    repeat (6) tick();
    send_and_check(18'sd19999, 18'sd20000, 4'b0100, "adapt inner");
    tick();
    send_and_check(-18'sd20000, -18'sd19999, 4'b1011, "adapt edge");
    chk("adapt thresh hold", 32'(thresh), 32'd20000);

    // Continuous stream: sync every 4 cycles, 128 back-to-back bits
    do_reset();
    for (int t = 0; t < 132; t++) begin
      if ((t % 4) == 0 && (t / 4) < 32) begin
        bus.di = lvl[(t / 4) % 4];
        bus.dq = lvl[(t / 16) % 4];
        bus.sync = 1'b1;
      end else begin
        bus.sync = 1'b0;
      end
      tick();
      if (t >= 2 && t <= 129) begin
        idx = (t - 2) / 4;
        e = {code[idx % 4], code[(idx / 4) % 4]};
        chk($sformatf("stream bit%0d", t - 2), {30'd0, bit_valid, bit_out},
            {30'd0, 1'b1, e[3 - ((t - 2) % 4)]});
      end else if (t >= 130) begin
        chk("stream tail", 32'(bit_valid), 32'd0);
      end
    end
    chk("stream overrun", 32'(overrun), 32'd0);
    chk("stream thresh", 32'(thresh), 32'd20000);

    // Mid-serialization reset (threshold is non-initial here)
    bus.di = -18'sd10000;
    bus.dq = 18'sd30000;
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst bit2", {30'd0, bit_valid, bit_out}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst sym", 32'(sym), 32'd0);
    chk("midrst sym_valid", 32'(sym_valid), 32'd0);
    chk("midrst bits", {30'd0, bit_valid, bit_out}, 32'd0);
    chk("midrst thresh", 32'(thresh), 32'd16384);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst quiet", {30'd0, bit_valid, bit_out}, 32'd0);
    end

    // Overrun: second sync two cycles after the first
    do_reset();
    bus.di = 18'sd30000;
    bus.dq = -18'sd10000;
    bus.sync = 1'b1;
    tick();                                   // capture A
    bus.sync = 1'b0;
    tick();                                   // slice A
    bus.di = -18'sd10000;
    bus.dq = 18'sd30000;
    bus.sync = 1'b1;
    tick();                                   // capture B, A b3 out
    bus.sync = 1'b0;
    chk("ovr A b3", {30'd0, bit_valid, bit_out}, 32'd2);
    tick();                                   // slice B, A b2 out
    chk("ovr A b2", {30'd0, bit_valid, bit_out}, 32'd2);
    chk("ovr not yet", 32'(overrun), 32'd0);
    chk("ovr sym B", 32'(sym), 32'b1100);
    for (int b = 3; b >= 0; b--) begin
      tick();
      chk($sformatf("ovr B bit%0d", b), {30'd0, bit_valid, bit_out},
          {30'd0, 1'b1, ((b >= 2) ? 1'b1 : 1'b0)});
      chk("ovr sticky", 32'(overrun), 32'd1);
    end
    tick();
    chk("ovr idle", {30'd0, bit_valid, bit_out}, 32'd0);
    repeat (8) tick();
    chk("ovr held", 32'(overrun), 32'd1);
    do_reset();
    chk("ovr cleared", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
